// File: rtl/sqrt_magsq_feeder.sv
// Magnitude-squared feeder for the square-root block: X*X + Y*Y via a bit-serial
// shift-add multiplier, issued as a one-cycle pulse, then paced on SQRT_DONE with a timeout.
module sqrt_magsq_feeder #(
  parameter int IN_W    = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic signed [IN_W-1:0] X,
  input  logic signed [IN_W-1:0] Y,
  output logic                   SQ_VALID,
  output logic [2*IN_W-1:0]      SQ,
  input  logic                   SQRT_DONE,
  output logic                   BUSY,
  output logic                   ERR
);

  localparam int SQ_W  = 2 * IN_W;
  localparam int CNT_W = $clog2(IN_W);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IN_W - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQX,
    S_SQY,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t            state_reg;
  logic [IN_W-1:0]   x_abs_reg;
  logic [IN_W-1:0]   y_abs_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [TMO_W-1:0]  tmo_reg;
  logic [SQ_W-1:0]   acc_reg;
  logic [SQ_W-1:0]   sq_reg;
  logic              sq_valid_reg;
  logic              err_reg;

  logic [IN_W-1:0]   x_u;
  logic [IN_W-1:0]   y_u;
  logic [IN_W-1:0]   x_abs_next;
  logic [IN_W-1:0]   y_abs_next;
  logic [IN_W-1:0]   op_sel;
  logic [CNT_W-1:0]  bit_idx;
  logic [SQ_W-1:0]   acc_next;
  logic [SQ_W-1:0]   term [IN_W];

  // Magnitude is held as IN_W-bit unsigned, so the most negative input maps to 2**(IN_W-1).
  always_comb begin
    x_u        = X;
    y_u        = Y;
    x_abs_next = x_u[IN_W-1] ? (~x_u + IN_W'(1)) : x_u;
    y_abs_next = y_u[IN_W-1] ? (~y_u + IN_W'(1)) : y_u;
  end

  // Counter runs down from IN_W-1, so the multiplier bit index walks LSB first.
  always_comb begin
    op_sel   = (state_reg == S_SQY) ? y_abs_reg : x_abs_reg;
    bit_idx  = CNT_MAX - cnt_reg;
    acc_next = acc_reg;
    if (op_sel[bit_idx]) begin
      acc_next = acc_reg + term[bit_idx];
    end
  end

  generate
    for (genvar gi = 0; gi < IN_W; gi++) begin : g_term
      assign term[gi] = {{IN_W{1'b0}}, op_sel} << gi;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      x_abs_reg    <= '0;
      y_abs_reg    <= '0;
      cnt_reg      <= '0;
      tmo_reg      <= '0;
      acc_reg      <= '0;
      sq_reg       <= '0;
      sq_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      sq_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (IN_VALID) begin
            x_abs_reg <= x_abs_next;
            y_abs_reg <= y_abs_next;
            acc_reg   <= '0;
            cnt_reg   <= CNT_MAX;
            state_reg <= S_SQX;
          end
        end
        S_SQX: begin
          acc_reg <= acc_next;
          if (cnt_reg == '0) begin
            cnt_reg   <= CNT_MAX;
            state_reg <= S_SQY;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_SQY: begin
          acc_reg <= acc_next;
          if (cnt_reg == '0) begin
            state_reg <= S_ISSUE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_ISSUE: begin
          sq_reg       <= acc_reg;
          sq_valid_reg <= 1'b1;
          tmo_reg      <= TMO_LOAD;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the expiry edge takes priority over the timeout.
          if (SQRT_DONE) begin
            state_reg <= S_IDLE;
          end else if (tmo_reg == '0) begin
            err_reg   <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            tmo_reg <= tmo_reg - 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign IN_READY = (state_reg == S_IDLE);
  assign BUSY     = (state_reg != S_IDLE);
  assign SQ_VALID = sq_valid_reg;
  assign SQ       = sq_reg;
  assign ERR      = err_reg;

endmodule

// File: tb/tb_sqrt_magsq_feeder.sv
// Directed bench for sqrt_magsq_feeder: latency, arithmetic corners, pacing, timeout and async reset.
module tb_sqrt_magsq_feeder;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              IN_VALID = 1'b0;
  logic              IN_READY;
  logic signed [7:0] X = '0;
  logic signed [7:0] Y = '0;
  logic              SQ_VALID;
  logic [15:0]       SQ;
  logic              SQRT_DONE = 1'b0;
  logic              BUSY;
  logic              ERR;

  int checks = 0;
  int errors = 0;

  sqrt_magsq_feeder #(.IN_W(8), .TIMEOUT(32)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .X(X), .Y(Y), .SQ_VALID(SQ_VALID), .SQ(SQ), .SQRT_DONE(SQRT_DONE),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Handshake on the next edge; returns at the falling edge just after it.
  task automatic send(input int xv, input int yv);
    @(negedge CLK);
    IN_VALID = 1'b1;
    X = xv[7:0];
    Y = yv[7:0];
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic wait_sq_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (SQ_VALID === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_done;
    @(negedge CLK);
    SQRT_DONE = 1'b1;
    @(negedge CLK);
    SQRT_DONE = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks += 5;
    if (SQ_VALID !== 1'b0) begin errors++; $display("FAIL reset_sq_valid got=%b want=0", SQ_VALID); end
    if (SQ !== 16'd0) begin errors++; $display("FAIL reset_sq got=%0d want=0", SQ); end
    if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", ERR); end
    if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", IN_READY); end
    $display("test_reset: SQ_VALID=%b SQ=%0d ERR=%b BUSY=%b IN_READY=%b", SQ_VALID, SQ, ERR, BUSY, IN_READY);
  endtask

  task automatic test_basic;
    int n;
    send(3, 4);
    checks += 2;
    if (IN_READY !== 1'b0) begin errors++; $display("FAIL basic_ready_drop got=%b want=0", IN_READY); end
    if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", BUSY); end
    wait_sq_valid(n);
    checks += 3;
    if (n != 17) begin errors++; $display("FAIL basic_latency got=%0d want=17", n); end
    if (SQ !== 16'd25) begin errors++; $display("FAIL basic_sq got=%0d want=25", SQ); end
    if (isqrt(int'(SQ) * 1024) != 160) begin errors++; $display("FAIL basic_sqrt_out got=%0d want=160", isqrt(int'(SQ) * 1024)); end
    @(negedge CLK);
    checks += 2;
    if (SQ_VALID !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%b want=0", SQ_VALID); end
    if (SQ !== 16'd25) begin errors++; $display("FAIL basic_sq_hold got=%0d want=25", SQ); end
    pulse_done();
    checks++;
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL basic_ready_after_done got=%b want=1", IN_READY); end
    $display("test_basic: X=3 Y=4 latency=%0d SQ=%0d sqrt_out=%0d", n, SQ, isqrt(int'(SQ) * 1024));
  endtask

  task automatic test_vectors;
    int tx[4] = '{-128, 127, 0, 5};
    int ty[4] = '{-128, -1, 0, 12};
    int te[4] = '{32768, 16130, 0, 169};
    int n;
    for (int k = 0; k < 4; k++) begin
      send(tx[k], ty[k]);
      wait_sq_valid(n);
      checks += 2;
      if (n != 17) begin errors++; $display("FAIL vec%0d_latency got=%0d want=17", k, n); end
      if (int'(SQ) != te[k]) begin errors++; $display("FAIL vec%0d_sq got=%0d want=%0d", k, SQ, te[k]); end
      pulse_done();
      checks++;
      if (IN_READY !== 1'b1) begin errors++; $display("FAIL vec%0d_ready got=%b want=1", k, IN_READY); end
      $display("test_vectors: X=%0d Y=%0d SQ=%0d latency=%0d", tx[k], ty[k], SQ, n);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int stray;
    stray = 0;
    @(negedge CLK);
    IN_VALID = 1'b1;
    X = 8'sd1;
    Y = 8'sd2;
    @(posedge CLK);
    @(negedge CLK);
    X = 8'sd50;
    Y = -8'sd50;
    checks++;
    if (IN_READY !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got=%b want=0", IN_READY); end
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      X = 8'(i * 7);
      Y = 8'(-i);
      if (IN_READY === 1'b1) stray++;
      if (SQ_VALID === 1'b1) begin
        n = i;
        break;
      end
    end
    checks += 3;
    if (n != 17) begin errors++; $display("FAIL b2b_latency1 got=%0d want=17", n); end
    if (SQ !== 16'd5) begin errors++; $display("FAIL b2b_sq1 got=%0d want=5", SQ); end
    if (stray != 0) begin errors++; $display("FAIL b2b_extra_accept got=%0d want=0", stray); end
    X = 8'sd6;
    Y = 8'sd8;
    repeat (3) @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b0) begin errors++; $display("FAIL b2b_wait_ready got=%b want=0", IN_READY); end
    pulse_done();
    checks++;
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done got=%b want=1", IN_READY); end
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    X = 8'sd1;
    Y = 8'sd1;
    checks++;
    if (IN_READY !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got=%b want=0", IN_READY); end
    wait_sq_valid(n);
    checks += 2;
    if (n != 17) begin errors++; $display("FAIL b2b_latency2 got=%0d want=17", n); end
    if (SQ !== 16'd100) begin errors++; $display("FAIL b2b_sq2 got=%0d want=100", SQ); end
    pulse_done();
    $display("test_back_to_back: first=5 second SQ=%0d latency=%0d stray=%0d", SQ, n, stray);
  endtask

  task automatic test_timeout;
    int n;
    int extra;
    send(2, 3);
    wait_sq_valid(n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (ERR === 1'b1) begin
        n = i;
        break;
      end
    end
    checks += 3;
    if (n != 32) begin errors++; $display("FAIL timeout_delay got=%0d want=32", n); end
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL timeout_idle got=%b want=1", IN_READY); end
    if (SQ !== 16'd13) begin errors++; $display("FAIL timeout_sq_hold got=%0d want=13", SQ); end
    extra = 0;
    repeat (5) begin
      @(negedge CLK);
      if (ERR === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL timeout_err_once got=%0d want=0", extra); end
    $display("test_timeout: err_delay=%0d SQ=%0d extra_err=%0d", n, SQ, extra);

    send(1, 1);
    wait_sq_valid(n);
    repeat (31) @(negedge CLK);
    SQRT_DONE = 1'b1;
    @(negedge CLK);
    SQRT_DONE = 1'b0;
    checks += 2;
    if (ERR !== 1'b0) begin errors++; $display("FAIL tie_err got=%b want=0", ERR); end
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL tie_idle got=%b want=1", IN_READY); end
    extra = 0;
    repeat (3) begin
      @(negedge CLK);
      if (ERR === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL tie_err_late got=%0d want=0", extra); end
    $display("test_timeout: done on expiry edge SQ=%0d err_seen=%0d", SQ, extra);
  endtask

  task automatic test_async_reset;
    int n;
    send(9, 9);
    repeat (10) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    checks += 3;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_sqy_busy got=%b want=0", BUSY); end
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL rst_sqy_ready got=%b want=1", IN_READY); end
    if (SQ !== 16'd0) begin errors++; $display("FAIL rst_sqy_sq got=%0d want=0", SQ); end
    @(negedge CLK);
    RST = 1'b0;
    $display("test_async_reset: reset in SQY BUSY=%b SQ=%0d", BUSY, SQ);

    send(9, 9);
    wait_sq_valid(n);
    checks++;
    if (SQ !== 16'd162) begin errors++; $display("FAIL rst_pre_sq got=%0d want=162", SQ); end
    #2 RST = 1'b1;
    #1;
    checks += 3;
    if (SQ_VALID !== 1'b0) begin errors++; $display("FAIL rst_wait_sq_valid got=%b want=0", SQ_VALID); end
    if (SQ !== 16'd0) begin errors++; $display("FAIL rst_wait_sq got=%0d want=0", SQ); end
    if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_wait_busy got=%b want=0", BUSY); end
    @(negedge CLK);
    RST = 1'b0;
    $display("test_async_reset: reset in WAIT SQ_VALID=%b SQ=%0d", SQ_VALID, SQ);

    send(5, 12);
    wait_sq_valid(n);
    checks += 2;
    if (n != 17) begin errors++; $display("FAIL rst_after_latency got=%0d want=17", n); end
    if (SQ !== 16'd169) begin errors++; $display("FAIL rst_after_sq got=%0d want=169", SQ); end
    pulse_done();
    $display("test_async_reset: post-reset X=5 Y=12 SQ=%0d latency=%0d", SQ, n);
  endtask

  task automatic test_ignore_done;
    int n;
    send(8, 6);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      SQRT_DONE = (i == 3 || i == 12);
      if (SQ_VALID === 1'b1) begin
        n = i;
        break;
      end
    end
    SQRT_DONE = 1'b0;
    checks += 2;
    if (n != 17) begin errors++; $display("FAIL ign_latency got=%0d want=17", n); end
    if (SQ !== 16'd100) begin errors++; $display("FAIL ign_sq got=%0d want=100", SQ); end
    repeat (5) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL ign_still_wait got=%b want=1", BUSY); end
    pulse_done();
    checks += 2;
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL ign_ready got=%b want=1", IN_READY); end
    if (ERR !== 1'b0) begin errors++; $display("FAIL ign_err got=%b want=0", ERR); end
    $display("test_ignore_done: SQ=%0d latency=%0d BUSY_in_wait held", SQ, n);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_ignore_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
